mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single byte-serial `main_memory` port between requester 0 (instruction fetch) and requester 1 (data load/store/loader). It sits between the CPU-side masters and `main_memory`. It arbitrates round-robin and holds a grant for bounded bursts. Each granted transaction is routed through to memory, and read data returns only to the owning requester.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, requester-id and mode definitions for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IFETCH = 1'b0;
    localparam req_id_t REQ_DATA   = 1'b1;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int BEAT_W = 8;

    // Saturating increment: the beat counter must never wrap back below the burst limit.
    function automatic logic [BEAT_W-1:0] beat_sat_inc(input logic [BEAT_W-1:0] b);
        return (b == {BEAT_W{1'b1}}) ? b : b + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select for mem_arbiter; MEM_ARB_FIXED_PRIO_EN makes m1 always win ties
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    v0,
    input  logic    v1,
    input  req_id_t last_owner,
    output logic    any_valid,
    output req_id_t winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Data requester wins whenever it is asking; fetch only gets the bus when data is quiet.
    always_comb begin
        any_valid = v0 | v1;
        winner    = v1 ? REQ_DATA : REQ_IFETCH;
    end
`else
    // Round-robin: on a tie the requester that did not finish the previous burst wins.
    always_comb begin
        any_valid = v0 | v1;
        winner    = REQ_IFETCH;
        if (v0 && v1) begin
            winner = ~last_owner;
        end else if (v1) begin
            winner = REQ_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester burst arbiter onto main_memory; MEM_ARB_FIXED_PRIO_EN selects fixed priority
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_mode,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_w_data,
    output logic              m0_r_data_valid,
    output logic [DATA_W-1:0] m0_r_data,
    input  logic              m1_mode,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_w_data,
    output logic              m1_r_data_valid,
    output logic [DATA_W-1:0] m1_r_data,
    output logic              mem_mode,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic              mem_ready,
    input  logic              mem_r_data_valid,
    input  logic [DATA_W-1:0] mem_r_data
);

    localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(BURST_MAX);

    arb_state_t        state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           last_owner_q, last_owner_d;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;

    logic              pick_any;
    req_id_t           pick_winner;

    logic              own_valid;
    logic              own_mode;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_w_data;
    logic              done;

    mem_arb_pick u_pick (
        .v0         (m0_valid),
        .v1         (m1_valid),
        .last_owner (last_owner_q),
        .any_valid  (pick_any),
        .winner     (pick_winner)
    );

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign m0_r_data = mem_r_data;
    assign m1_r_data = mem_r_data;
    assign beat_inc  = beat_sat_inc(beat_q);

    // Request fields of whichever requester currently owns the bus.
    always_comb begin
        own_valid  = m0_valid;
        own_mode   = m0_mode;
        own_addr   = m0_addr;
        own_w_data = m0_w_data;
        if (owner_q == REQ_DATA) begin
            own_valid  = m1_valid;
            own_mode   = m1_mode;
            own_addr   = m1_addr;
            own_w_data = m1_w_data;
        end
    end

    // Next-state, grant bookkeeping and all bus-facing outputs.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        beat_d          = beat_q;
        m0_ready        = 1'b0;
        m1_ready        = 1'b0;
        m0_r_data_valid = 1'b0;
        m1_r_data_valid = 1'b0;
        mem_valid       = 1'b0;
        mem_mode        = MODE_READ;
        mem_addr        = '0;
        mem_w_data      = '0;
        done            = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_winner;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_valid  = own_valid;
                mem_mode   = own_mode;
                mem_addr   = own_addr;
                mem_w_data = own_w_data;
                m0_ready   = (owner_q == REQ_IFETCH) && mem_ready;
                m1_ready   = (owner_q == REQ_DATA) && mem_ready;
                if (own_valid && mem_ready) begin
                    if (own_mode == MODE_WRITE) begin
                        beat_d = beat_inc;
                        done   = 1'b1;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (!own_valid) begin
                    // Owner withdrew before any handshake: release the bus untouched.
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                m0_r_data_valid = (owner_q == REQ_IFETCH) && mem_r_data_valid;
                m1_r_data_valid = (owner_q == REQ_DATA) && mem_r_data_valid;
                if (mem_r_data_valid) begin
                    beat_d = beat_inc;
                    done   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed beat either continues the burst or hands the bus back.
        if (done) begin
            if (own_valid && (beat_inc < BURST_LIM)) begin
                state_d = GRANT;
            end else begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
        end
    end

    // State register; last_owner resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IFETCH;
            last_owner_q <= REQ_DATA;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with memory and requester models
module tb_mem_arbiter;

    localparam int BM = 4;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam int TIE_WIN = 1;
`else
    localparam int TIE_WIN = 0;
`endif

    typedef struct packed {
        logic        mode;
        logic [63:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mv, mmode;
    logic [63:0] maddr [2];
    logic [7:0]  mwd [2];
    wire  [1:0]  mrdy, mrdv;
    wire  [7:0]  mrd0, mrd1;
    wire         mem_mode, mem_valid;
    wire  [63:0] mem_addr;
    wire  [7:0]  mem_w_data;
    logic        mem_ready, mem_r_data_valid;
    logic [7:0]  mem_r_data;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(8), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .m0_mode(mmode[0]), .m0_valid(mv[0]), .m0_ready(mrdy[0]), .m0_addr(maddr[0]),
        .m0_w_data(mwd[0]), .m0_r_data_valid(mrdv[0]), .m0_r_data(mrd0),
        .m1_mode(mmode[1]), .m1_valid(mv[1]), .m1_ready(mrdy[1]), .m1_addr(maddr[1]),
        .m1_w_data(mwd[1]), .m1_r_data_valid(mrdv[1]), .m1_r_data(mrd1),
        .mem_mode(mem_mode), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_ready(mem_ready), .mem_r_data_valid(mem_r_data_valid), .mem_r_data(mem_r_data)
    );

    txn_t       mq [2][$];
    logic [7:0] exp_rd [2][$];
    logic [7:0] mem_arr [256];
    logic [7:0] shadow [256];
    int         errors = 0;
    int         checks = 0;
    int         rdy_mode = 0;
    int         lat_cfg = 1;
    bit         lat_rand = 1'b0;
    bit         stray = 1'b0;
    bit         rd_pend = 1'b0;
    int         rd_lat = 0;
    logic [7:0] rd_idx = '0;
    bit         en [2] = '{1'b1, 1'b1};
    int         last_hs = -1;
    int         wait_cnt [2] = '{0, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic mode, input logic [63:0] addr, input logic [7:0] data);
        txn_t t;
        t.mode = mode;
        t.addr = addr;
        t.data = data;
        mq[i].push_back(t);
    endtask

    // One clock: drive at negedge, sample just after, advance both models.
    task automatic tick();
        bit   real_rsp;
        bit   hs [2];
        bit   mhs;
        txn_t t;
        @(negedge clk);
        mem_r_data_valid = 1'b0;
        real_rsp = 1'b0;
        if (rd_pend) begin
            if (rd_lat == 0) begin
                mem_r_data_valid = 1'b1;
                mem_r_data = mem_arr[rd_idx];
                rd_pend = 1'b0;
                real_rsp = 1'b1;
            end else begin
                rd_lat--;
            end
        end
        if (stray) begin
            mem_r_data_valid = 1'b1;
            mem_r_data = 8'h3C;
            stray = 1'b0;
        end
        mem_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 0; i < 2; i++) begin
            mv[i]    = en[i] && (mq[i].size() > 0);
            mmode[i] = mv[i] ? mq[i][0].mode : 1'b0;
            maddr[i] = mv[i] ? mq[i][0].addr : '0;
            mwd[i]   = mv[i] ? mq[i][0].data : '0;
        end
        #1;
        for (int i = 0; i < 2; i++) hs[i] = mv[i] && mrdy[i];
        mhs = mem_valid && mem_ready;
        check("ready_excl", mrdy, (mrdy == 2'b11) ? 2'b00 : mrdy);
        check("hs_match", mhs, hs[0] || hs[1]);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rdv_route%0d", i), mrdv[i], real_rsp && (exp_rd[i].size() > 0));
            if (mrdv[i] && exp_rd[i].size() > 0)
                check($sformatf("rdata%0d", i), (i == 0) ? mrd0 : mrd1, exp_rd[i].pop_front());
        end
        last_hs = hs[0] ? 0 : hs[1] ? 1 : -1;
        if (mhs) begin
            if (mem_mode == 1'b0) begin
                check("rd_overlap", rd_pend, 1'b0);
                rd_pend = 1'b1;
                rd_idx  = mem_addr[7:0];
                rd_lat  = lat_rand ? int'($urandom_range(0, 2)) : lat_cfg;
            end else begin
                mem_arr[mem_addr[7:0]] = mem_w_data;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                t = mq[i].pop_front();
                check($sformatf("addr%0d", i), mem_addr, t.addr);
                check($sformatf("mode%0d", i), mem_mode, t.mode);
                if (t.mode) begin
                    check($sformatf("wdata%0d", i), mem_w_data, t.data);
                    shadow[t.addr[7:0]] = t.data;
                end else begin
                    exp_rd[i].push_back(shadow[t.addr[7:0]]);
                end
            end
        end
        // A pending requester may watch at most one burst of the other go by.
        for (int i = 0; i < 2; i++) begin
            if (!mv[i] || hs[i]) begin
                wait_cnt[i] = 0;
            end else if (hs[1-i]) begin
                wait_cnt[i]++;
`ifdef MEM_ARB_FIXED_PRIO_EN
                if (i == 1) check("wait_bound1", wait_cnt[i] <= BM, 1'b1);
`else
                check($sformatf("wait_bound%0d", i), wait_cnt[i] <= BM, 1'b1);
`endif
            end
        end
    endtask

    task automatic drain(input string tag, input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            done = (mq[0].size() == 0) && (mq[1].size() == 0) && (exp_rd[0].size() == 0) &&
                   (exp_rd[1].size() == 0) && !rd_pend;
        end
        check(tag, done, 1'b1);
        tick();
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, mrdy, 2'b00);
        check({tag, "_rdv"}, mrdv, 2'b00);
        check({tag, "_mem_valid"}, mem_valid, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 64'h0);
        check({tag, "_mem_wdata"}, mem_w_data, 8'h0);
        check({tag, "_mem_mode"}, mem_mode, 1'b0);
    endtask

    initial begin
        bit got;
        int bad;
        int exp_hs;
        rst = 1'b0;
        mv = '0;
        mmode = '0;
        maddr = '{64'h0, 64'h0};
        mwd = '{8'h0, 8'h0};
        mem_ready = 1'b0;
        mem_r_data_valid = 1'b0;
        mem_r_data = '0;
        for (int a = 0; a < 256; a++) begin
            mem_arr[a] = 8'hA5 ^ 8'(a);
            shadow[a]  = 8'hA5 ^ 8'(a);
        end

        // Reset and quiet release
        repeat (3) @(negedge clk);
        #1;
        check_quiet("in_reset");
        rst = 1'b1;
        tick();
        check_quiet("post_reset");

        // Both requesters streaming writes from reset
        for (int k = 0; k < 20; k++) begin
            push(0, 1'b1, 64'h2010 + 64'(k), 8'(k + 1));
            push(1, 1'b1, 64'h2090 + 64'(k), 8'(k + 8'h40));
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_hs = (k % 5 == 0) ? -1 : (TIE_WIN == 1) ? 1 : (k / 5) % 2;
            check($sformatf("burst_seq_c%0d", k), 64'(last_hs), 64'(exp_hs));
        end
        drain("burst_drain", 300);

        // Single m0 read of 0x1000 returning 0xA5
        lat_cfg = 2;
        push(0, 1'b0, 64'h1000, 8'h00);
        tick();
        check("rd_arb_idle", mem_valid, 1'b0);
        tick();
        check("rd_present", mem_valid, 1'b1);
        check("rd_addr", mem_addr, 64'h1000);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            check("rd_m1_silent", mrdv[1], 1'b0);
            if (mrdv[0]) begin
                got = 1'b1;
                check("rd_data_a5", mrd0, 8'hA5);
            end
        end
        check("rd_returned", got, 1'b1);
        drain("rd_drain", 20);

        // m0 waits behind m1's outstanding read
        lat_cfg = 3;
        push(1, 1'b0, 64'h85, 8'h00);
        tick();
        check("wr_idle", 64'(last_hs), 64'(-1));
        tick();
        check("wr_m1_accept", 64'(last_hs), 64'd1);
        push(0, 1'b1, 64'h20, 8'h77);
        got = 1'b0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            check("wr_m0_blocked", mrdy[0], 1'b0);
            got = mrdv[1];
        end
        check("wr_m1_rsp", got, 1'b1);
        tick();
        check("wr_gap", 64'(last_hs), 64'(-1));
        tick();
        check("wr_m0_grant", 64'(last_hs), 64'd0);
        drain("wr_drain", 20);

        // Owner withdraws before memory is ready
        rdy_mode = 1;
        push(0, 1'b1, 64'h21, 8'h55);
        tick();
        check("drop_idle", 64'(last_hs), 64'(-1));
        tick();
        check("drop_present", mem_valid, 1'b1);
        check("drop_no_hs", 64'(last_hs), 64'(-1));
        en[0] = 1'b0;
        push(1, 1'b1, 64'hA1, 8'h66);
        tick();
        check("drop_released", mem_valid, 1'b0);
        rdy_mode = 0;
        tick();
        check("drop_back_idle", mem_valid, 1'b0);
        tick();
        check("drop_other", 64'(last_hs), 64'd1);
        en[0] = 1'b1;
        drain("drop_drain", 20);

        // Reset during an outstanding read, then a stray response
        lat_cfg = 8;
        push(0, 1'b0, 64'h30, 8'h00);
        tick();
        tick();
        check("rst_rd_accept", 64'(last_hs), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_quiet("rst_async");
        rd_pend = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            exp_rd[i].delete();
            wait_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stray = 1'b1;
        tick();
        check("stray_rdv", mrdv, 2'b00);
        check("stray_idle", mem_valid, 1'b0);
        push(0, 1'b1, 64'h40, 8'h11);
        push(1, 1'b1, 64'hC0, 8'h22);
        tick();
        check("tie_idle", 64'(last_hs), 64'(-1));
        tick();
        check("tie_winner", 64'(last_hs), 64'(TIE_WIN));
        drain("tie_drain", 30);

        // Randomized traffic with random ready and read latency
        rdy_mode = 2;
        lat_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) begin
                logic [63:0] a;
                a = {$urandom, $urandom};
                a[7] = 1'(i);
                push(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
            end
        end
        drain("rand_drain", 4000);

        bad = 0;
        for (int a = 0; a < 256; a++) if (mem_arr[a] !== shadow[a]) bad++;
        check("mem_image", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
